pad_ctrl_array: RTL and testbench

PAD_CTRL_ARRAY -- requirements
Module: pad_ctrl_array

---
 rtl/pad_ctrl_array.sv | 108 ++++++++++
 tb/tb_pad_ctrl_array.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pad_ctrl_array.sv
// Pad control array: a combinational output path to the pad cells, and a
// synchronised, glitch-filtered input path with sticky edge events per pad.
module pad_ctrl_array #(
    parameter int N_PADS = 32,
    parameter int CFG_W  = 6,
    parameter int FILT_W = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [N_PADS-1:0][CFG_W-1:0]   pad_cfg_i,
    input  logic [N_PADS-1:0]              oe_i,
    input  logic [N_PADS-1:0]              out_i,
    output logic [N_PADS-1:0]              in_o,
    output logic [N_PADS-1:0]              pad_oen_o,
    output logic [N_PADS-1:0]              pad_i_o,
    output logic [N_PADS-1:0]              pad_pen_o,
    input  logic [N_PADS-1:0]              pad_in_i,
    input  logic [FILT_W-1:0]              filt_thr_i,
    input  logic [N_PADS-1:0]              evt_clr_i,
    output logic [N_PADS-1:0]              evt_o,
    output logic                           evt_irq_o
);

    localparam int CFG_PULL_DIS = 0;
    localparam int CFG_FILT_EN  = 1;
    localparam int CFG_RISE_EN  = 2;
    localparam int CFG_FALL_EN  = 3;
    localparam int CFG_FORCE_OD = 4;
    localparam int CFG_INV      = 5;

    for (genvar n = 0; n < N_PADS; n++) begin : g_pad
        logic              s1;
        logic              s2;
        logic              f;
        logic              f_d;
        logic [FILT_W-1:0] cnt;
        logic              evt_q;
        logic              in_v;
        logic              evt_set;

        // Output path: purely combinational, independent of reset
        always_comb begin
            pad_oen_o[n] = ~(oe_i[n] & ~pad_cfg_i[n][CFG_FORCE_OD]);
            pad_i_o[n]   = out_i[n];
            pad_pen_o[n] = ~pad_cfg_i[n][CFG_PULL_DIS];
        end

        // Two-flop synchroniser for the asynchronous pad receive data
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= pad_in_i[n];
                s2 <= s1;
            end
        end

        // Glitch filter: a mismatch must persist until the counter reaches the
        // threshold; >= (not ==) lets a threshold lowered mid-count take effect
        // on the very next mismatch cycle.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                f   <= 1'b0;
                cnt <= '0;
            end else if (!pad_cfg_i[n][CFG_FILT_EN]) begin
                f   <= s2;
                cnt <= '0;
            end else if (s2 == f) begin
                cnt <= '0;
            end else if (cnt >= filt_thr_i) begin
                f   <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        // Event qualification: only a change of f is an edge; polarity is the
        // new in_o value, so toggling the invert bit alone never raises one.
        always_comb begin
            in_v    = f ^ pad_cfg_i[n][CFG_INV];
            evt_set = (f ^ f_d) &
                      ((in_v & pad_cfg_i[n][CFG_RISE_EN]) |
                       (~in_v & pad_cfg_i[n][CFG_FALL_EN]));
        end

        // Edge history and sticky event flag; a coincident set beats clear
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                f_d   <= 1'b0;
                evt_q <= 1'b0;
            end else begin
                f_d   <= f;
                evt_q <= (evt_q & ~evt_clr_i[n]) | evt_set;
            end
        end

        assign in_o[n]  = in_v;
        assign evt_o[n] = evt_q;
    end

    // Interrupt is a plain OR so it tracks evt_o with no added latency
    always_comb begin
        evt_irq_o = |evt_o;
    end

endmodule

// File: tb/tb_pad_ctrl_array.sv
// Directed bench for pad_ctrl_array: table-driven output-path vectors plus
// hand-written sequences for filter, event, invert and reset corner cases.
module tb_pad_ctrl_array;

    localparam int N = 32;
    localparam int FW = 4;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic [N-1:0][5:0]   pad_cfg_i;
    logic [N-1:0]        oe_i;
    logic [N-1:0]        out_i;
    logic [N-1:0]        in_o;
    logic [N-1:0]        pad_oen_o;
    logic [N-1:0]        pad_i_o;
    logic [N-1:0]        pad_pen_o;
    logic [N-1:0]        pad_in_i;
    logic [FW-1:0]       filt_thr_i;
    logic [N-1:0]        evt_clr_i;
    logic [N-1:0]        evt_o;
    logic                evt_irq_o;

    int checks = 0;
    int failures = 0;

    pad_ctrl_array #(.N_PADS(N), .CFG_W(6), .FILT_W(FW)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .pad_cfg_i  (pad_cfg_i),
        .oe_i       (oe_i),
        .out_i      (out_i),
        .in_o       (in_o),
        .pad_oen_o  (pad_oen_o),
        .pad_i_o    (pad_i_o),
        .pad_pen_o  (pad_pen_o),
        .pad_in_i   (pad_in_i),
        .filt_thr_i (filt_thr_i),
        .evt_clr_i  (evt_clr_i),
        .evt_o      (evt_o),
        .evt_irq_o  (evt_irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic pull_dis;
        logic force_od;
        logic oe;
        logic out;
        logic exp_oen;
        logic exp_i;
        logic exp_pen;
    } vec_t;

    vec_t vecs[8];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        rst_ni     = 1'b0;
        pad_cfg_i  = '0;
        pad_cfg_i[2][5] = 1'b1;
        oe_i       = '0;
        out_i      = '0;
        pad_in_i   = '0;
        filt_thr_i = '0;
        evt_clr_i  = '0;

        // Reset state: in_o reflects the invert bits only
        tick(2);
        chk("reset_in_o", 64'(in_o), 64'h4);
        chk("reset_evt", 64'(evt_o), 64'h0);
        chk("reset_irq", 64'(evt_irq_o), 64'h0);
        rst_ni = 1'b1;
        tick(1);

        // Output path on pad 3, zero latency
        for (int i = 0; i < 8; i++) begin
            pad_cfg_i[3][0] = vecs[i].pull_dis;
            pad_cfg_i[3][4] = vecs[i].force_od;
            oe_i[3]  = vecs[i].oe;
            out_i[3] = vecs[i].out;
            #1;
            chk($sformatf("oen_v%0d", i), 64'(pad_oen_o[3]), 64'(vecs[i].exp_oen));
            chk($sformatf("drv_v%0d", i), 64'(pad_i_o[3]), 64'(vecs[i].exp_i));
            chk($sformatf("pen_v%0d", i), 64'(pad_pen_o[3]), 64'(vecs[i].exp_pen));
        end
        pad_cfg_i[3] = '0;
        oe_i = '0;
        out_i = '0;
        tick(1);

        // Filter off: exactly 3 cycles pad-to-in_o
        pad_in_i[0] = 1'b1;
        tick(1); chk("lat_c1", 64'(in_o[0]), 64'h0);
        tick(1); chk("lat_c2", 64'(in_o[0]), 64'h0);
        tick(1); chk("lat_c3", 64'(in_o[0]), 64'h1);
        pad_in_i[0] = 1'b0;
        tick(4);
        chk("lat_fall", 64'(in_o[0]), 64'h0);

        // Filter on, T=4: 4-cycle pulse suppressed, 6-cycle pulse passes at cycle 7
        pad_cfg_i[0][1] = 1'b1;
        filt_thr_i = 4'd4;
        tick(2);
        pad_in_i[0] = 1'b1;
        tick(4);
        pad_in_i[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk($sformatf("glitch4_c%0d", i), 64'(in_o[0]), 64'h0);
        end
        pad_in_i[0] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            chk($sformatf("pulse6_c%0d", i), 64'(in_o[0]), (i == 7) ? 64'h1 : 64'h0);
            if (i == 6) pad_in_i[0] = 1'b0;
        end
        tick(12);
        chk("pulse6_settle", 64'(in_o[0]), 64'h0);

        // Threshold lowered below the running count releases on the next mismatch
        pad_cfg_i[1][1] = 1'b1;
        filt_thr_i = 4'd7;
        pad_in_i[1] = 1'b1;
        tick(7);
        chk("thr_chg_before", 64'(in_o[1]), 64'h0);
        filt_thr_i = 4'd3;
        tick(1);
        chk("thr_chg_after", 64'(in_o[1]), 64'h1);
        pad_in_i[1] = 1'b0;
        filt_thr_i = 4'd7;
        tick(14);
        chk("thr_chg_fall", 64'(in_o[1]), 64'h0);

        // Reset mid-count (T=7, count 5) aborts; 7 high cycles afterwards do not propagate
        pad_cfg_i[1][2] = 1'b1;
        pad_in_i[1] = 1'b1;
        tick(7);
        rst_ni = 1'b0;
        tick(1);
        rst_ni = 1'b1;
        chk("rst_mid_in", 64'(in_o[1]), 64'h0);
        chk("rst_mid_evt", 64'(evt_o), 64'h0);
        chk("rst_mid_irq", 64'(evt_irq_o), 64'h0);
        for (int i = 0; i < 7; i++) begin
            tick(1);
            chk($sformatf("post_rst_c%0d", i), 64'(in_o[1]), 64'h0);
        end
        pad_in_i[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk($sformatf("post_rst_tail%0d", i), 64'(in_o[1]), 64'h0);
        end
        chk("post_rst_evt", 64'(evt_o[1]), 64'h0);

        // Invert toggle alone: immediate in_o change, no event
        pad_cfg_i[2][2] = 1'b1;
        pad_cfg_i[2][3] = 1'b1;
        pad_cfg_i[2][5] = 1'b0;
        #1;
        chk("inv_off", 64'(in_o[2]), 64'h0);
        tick(2);
        pad_cfg_i[2][5] = 1'b1;
        #1;
        chk("inv_on", 64'(in_o[2]), 64'h1);
        tick(3);
        chk("inv_evt", 64'(evt_o[2]), 64'h0);
        chk("inv_irq", 64'(evt_irq_o), 64'h0);

        // Rising-edge event on pad 5
        pad_cfg_i[5] = 6'b000100;
        pad_in_i[5] = 1'b1;
        tick(3);
        chk("evt_in_rise", 64'(in_o[5]), 64'h1);
        chk("evt_pre", 64'(evt_o[5]), 64'h0);
        chk("irq_pre", 64'(evt_irq_o), 64'h0);
        tick(1);
        chk("evt_set", 64'(evt_o[5]), 64'h1);
        chk("irq_set", 64'(evt_irq_o), 64'h1);
        evt_clr_i[5] = 1'b1;
        tick(1);
        evt_clr_i[5] = 1'b0;
        chk("evt_clr", 64'(evt_o[5]), 64'h0);
        chk("irq_clr", 64'(evt_irq_o), 64'h0);
        pad_in_i[5] = 1'b0;
        tick(5);
        chk("evt_fall_dis", 64'(evt_o[5]), 64'h0);
        pad_in_i[5] = 1'b1;
        tick(3);
        evt_clr_i[5] = 1'b1;
        tick(1);
        evt_clr_i[5] = 1'b0;
        chk("evt_set_wins", 64'(evt_o[5]), 64'h1);
        tick(1);
        chk("evt_sticky", 64'(evt_o[5]), 64'h1);

        // Falling-edge event once enabled
        pad_cfg_i[5][3] = 1'b1;
        evt_clr_i[5] = 1'b1;
        tick(1);
        evt_clr_i[5] = 1'b0;
        chk("fall_clr", 64'(evt_o[5]), 64'h0);
        pad_in_i[5] = 1'b0;
        tick(3);
        chk("fall_in", 64'(in_o[5]), 64'h0);
        chk("fall_pre", 64'(evt_o[5]), 64'h0);
        tick(1);
        chk("fall_set", 64'(evt_o[5]), 64'h1);
        chk("fall_irq", 64'(evt_irq_o), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
